// File: rtl/seq_memory_stage.sv
// Y86-64 SEQ memory stage: little-endian data memory, processor status FSM
// and retired-instruction counter.
module seq_memory_stage #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic [63:0]      valE,
  input  logic [63:0]      valA,
  input  logic [63:0]      valP,
  output logic [63:0]      valM,
  output logic             dmem_error,
  output logic [1:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  // Contents survive rst; the bench may preload this array hierarchically.
  logic [7:0] mem [MEM_BYTES];

  logic          mem_rd;
  logic          mem_wr;
  logic [63:0]   addr;
  logic [63:0]   wdata;
  logic [AW-1:0] base;
  logic          wr_en;

  logic [1:0]       stat_next;
  logic [CNT_W-1:0] retired_next;

  // Operation decode: which access, at which address, with which data.
  always_comb begin
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    addr   = '0;
    wdata  = '0;
    case (icode)
      I_RMMOVQ: begin mem_wr = 1'b1; addr = valE; wdata = valA; end
      I_CALL:   begin mem_wr = 1'b1; addr = valE; wdata = valP; end
      I_PUSHQ:  begin mem_wr = 1'b1; addr = valE; wdata = valA; end
      I_MRMOVQ: begin mem_rd = 1'b1; addr = valE; end
      I_RET:    begin mem_rd = 1'b1; addr = valA; end
      I_POPQ:   begin mem_rd = 1'b1; addr = valA; end
      default:  ;
    endcase
  end

  // Full 64-bit compare so addresses near 2^64 cannot alias low memory.
  assign dmem_error = (mem_rd | mem_wr) && (addr > MAX_ADDR);
  assign base       = addr[AW-1:0];

  always_comb begin
    valM = '0;
    if (mem_rd && !dmem_error) begin
      for (int k = 0; k < 8; k++) begin
        valM[8*k +: 8] = mem[base + AW'(k)];
      end
    end
  end

  // Writes are suppressed during reset and once the machine has faulted.
  assign wr_en = mem_wr && !dmem_error && (stat == S_AOK) &&
                 instr_valid && !imem_error && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        mem[base + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  // Status next-state: first matching fault wins; non-AOK states are sticky.
  always_comb begin
    stat_next    = stat;
    retired_next = retired;
    case (stat)
      S_AOK: begin
        if (imem_error)        stat_next = S_ADR;
        else if (!instr_valid) stat_next = S_INS;
        else if (dmem_error)   stat_next = S_ADR;
        else if (icode == I_HALT) stat_next = S_HLT;
        else                   retired_next = retired + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat    <= S_AOK;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      stat    <= stat_next;
      halted  <= (stat_next != S_AOK);
      retired <= retired_next;
    end
  end

endmodule

// File: doc/seq_memory_stage.md
Name: seq_memory_stage

Overview:
- Memory stage of the Y86-64 SEQ processor. It sits directly downstream of `execute` and consumes its `valE` together with the decode-stage `valA` and fetch-stage `valP`.
- It performs data-memory reads and writes into a byte-addressed little-endian array and produces `valM`.
- It owns the processor status state machine (AOK/HLT/ADR/INS), which freezes architectural side effects once a fault or halt occurs.
- It keeps a retired-instruction counter.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes; must be ≥ 8.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- icode  input  4  instruction code from fetch
- instr_valid  input  1  fetch decoded a legal icode/ifun
- imem_error  input  1  fetch address out of range
- valE  input  64  ALU result from execute
- valA  input  64  register operand A
- valP  input  64  incremented PC
- valM  output  64  data read from memory
- dmem_error  output  1  data address out of range (combinational)
- stat  output  2  registered status: 0 = AOK, 1 = HLT, 2 = ADR, 3 = INS
- halted  output  1  high when stat ≠ AOK
- retired  output  CNT_W  count of instructions retired with AOK

Behaviour:
- Operation decode (combinational):
  - Writes:
    - icode 4 (rmmovq): M[valE] ← valA
    - icode 8 (call): M[valE] ← valP
    - icode A (pushq): M[valE] ← valA
  - Reads:
    - icode 5 (mrmovq): addr = valE
    - icode 9 (ret): addr = valA
    - icode B (popq): addr = valA
  - All other icodes: no memory access.
- Address is 64-bit unsigned. `dmem_error = (read | write) && (addr > MEM_BYTES-8)`. This is a full 64-bit compare, so addresses near 2^64 flag an error and never wrap.
- Read (combinational): `valM = {M[addr+7] … M[addr]}` (little-endian) when a read op is active and no `dmem_error`; otherwise `valM = 0`.
- Write (at posedge clk) occurs only when all of the following hold:
  - write op active
  - `dmem_error = 0`
  - `stat == AOK`
  - `instr_valid = 1`
  - `imem_error = 0`
  
  All 8 bytes are written in the same edge, little-endian.
- Memory contents are not affected by `rst`. The array is preloadable from the bench.
- Status FSM, states AOK / HLT / ADR / INS.
  - On reset: AOK, `retired = 0`.
  - At posedge in AOK, first match wins:
    1. `imem_error` → ADR
    2. `!instr_valid` → INS
    3. `dmem_error` → ADR
    4. `icode == 0` → HLT
    5. otherwise stay AOK and `retired += 1` (wraps modulo 2^CNT_W).
  - HLT, ADR and INS are sticky until `rst`. In these states:
    - no writes occur
    - `retired` holds
    - `valM` and `dmem_error` still evaluate combinationally.
  - The halting instruction itself is not counted.
- `halted = (stat != AOK)`, derived from the registered state.
- `rst` asserted mid-cycle:
  - `stat`, `halted` and `retired` clear immediately.
  - No write occurs on any edge while `rst` is high.
- Read and write of the same address never happen in one instruction. A read in cycle N+1 returns data written at the edge ending cycle N.

Test Plan:
- rmmovq then mrmovq:
  - Cycle 1: icode=4, valE=16, valA=64'h1122334455667788.
  - Cycle 2: icode=5, valE=16.
  - Expected: valM=64'h1122334455667788, byte M[16]=8'h88, retired=2, stat=0.
- call/ret:
  - Cycle 1: icode=8, valE=120, valP=64'h40.
  - Cycle 2: icode=9, valA=120.
  - Expected: valM=64'h40, stat=0.
- Boundary with MEM_BYTES=1024:
  - icode=A, valE=1016: write succeeds, dmem_error=0.
  - Next: icode=A, valE=1017: dmem_error=1, no write, stat=2 after the edge, halted=1.
  - Next: icode=4, valE=0: no write (M[0] unchanged), retired frozen.
- Wrap guard: icode=5, valE=64'hFFFF_FFFF_FFFF_FFFC → dmem_error=1, valM=0, stat=2 next edge.
- Priority and INS:
  - imem_error=1 with instr_valid=0 → stat=2.
  - After rst, instr_valid=0 → stat=3.
  - After rst, icode=0 → stat=1, retired unchanged.
- Async reset:
  - Retire 3 nops (icode=1) → retired=3.
  - Assert rst between edges → retired=0 and stat=0 before the next edge; previously written memory data is still readable.
